// File: rtl/hazard_stall_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Pipeline sequencer that works alongside the EX-stage forwarding unit. It
//   covers the hazards that forwarding cannot resolve:
//     - load-use,
//     - operand dependencies of a compare branch resolved in ID,
//     - HI/LO accesses while the multi-cycle multiply/divide unit is busy.
//   It freezes PC and IF/ID, injects ID/EX bubbles, and flushes IF/ID on a
//   taken branch.
//
// Parameters:
//   MDU_LAT  cycles from mdu_start to MDU result valid (2..15)
//   REG_W    register-specifier width
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   rs_id, rt_id     ID-stage source registers
//   id_uses_rt       ID instruction reads rt as a source
//   id_branch        ID instruction is beq/bne, resolved in ID
//   id_uses_hilo     ID instruction is mfhi/mflo/mult/div
//   branch_taken     ID branch comparator result (meaningful with id_branch)
//   ex_reg_write     EX instruction writes the register file
//   ex_mem_read      EX instruction is a load
//   ex_rd            EX destination register
//   mem_mem_read     MEM instruction is a load
//   mem_rd           MEM destination register
//   mdu_start        mult/div issuing in EX this cycle
//   pc_write         1 = PC may update
//   ifid_write       1 = IF/ID may load
//   idex_bubble      1 = zero the control fields entering ID/EX
//   ifid_flush       1 = IF/ID loads a NOP (taken branch)
//   mdu_busy         MDU result pending
//   stall_cycles     running count of stalled cycles (saturating)
//
// Configuration:
//   STALL_STATS_EN   when defined, stall_cycles counts every clock with
//                    pc_write low and saturates at all-ones; otherwise
//                    stall_cycles is tied to zero.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MDU_LAT = 8,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_uses_hilo,
    input  logic             branch_taken,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mdu_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             mdu_busy,
    output logic [31:0]      stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] MDU_LAT_C = 4'(MDU_LAT);

    state_t     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;
    logic [3:0] mdu_cnt_q, mdu_cnt_d;

    logic ex_match, mem_match;
    logic load_use, br_ex_alu, br_ex_load, br_mem_load;
    logic reg_hazard, mdu_pending, mdu_hazard;
    logic stall, flush;

    // A producer only matters if it targets a real register ($0 never
    // creates a hazard) and the ID instruction actually reads that register.
    assign ex_match  = (ex_rd != '0) &&
                       ((rs_id == ex_rd) || (id_uses_rt && (rt_id == ex_rd)));
    assign mem_match = (mem_rd != '0) &&
                       ((rs_id == mem_rd) || (id_uses_rt && (rt_id == mem_rd)));

    // Branches compare in ID, so even ALU results in EX and loads in MEM are
    // too late to forward to them; ordinary instructions only trip on a load
    // sitting in EX.
    assign load_use    = ex_mem_read && ex_match;
    assign br_ex_alu   = id_branch && ex_reg_write && !ex_mem_read && ex_match;
    assign br_ex_load  = id_branch && ex_mem_read && ex_match;
    assign br_mem_load = id_branch && mem_mem_read && mem_match;
    assign reg_hazard  = load_use || br_ex_alu || br_ex_load || br_mem_load;

    // mdu_start counts as busy in its own cycle so a HI/LO reader sitting
    // right behind the issuing mult/div is caught immediately.
    assign mdu_pending = (mdu_cnt_q != '0) || mdu_start;
    assign mdu_hazard  = id_uses_hilo && mdu_pending;

    // Next-state and stall/flush decode. Only a branch behind a load in EX
    // needs more than the detect cycle; that extra cycle is served by STALL,
    // which deliberately ignores the hazard inputs. MDU hazards take
    // precedence over register hazards, and any stall suppresses the flush.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        stall       = 1'b0;
        flush       = 1'b0;
        case (state_q)
            RUN: begin
                if (mdu_hazard) begin
                    stall   = 1'b1;
                    state_d = MDU_WAIT;
                end else if (reg_hazard) begin
                    stall = 1'b1;
                    if (br_ex_load) begin
                        stall_cnt_d = 2'd1;
                        state_d     = STALL;
                    end
                end else if (id_branch && branch_taken) begin
                    flush = 1'b1;
                end
            end
            STALL: begin
                if (stall_cnt_q != '0) begin
                    stall       = 1'b1;
                    stall_cnt_d = stall_cnt_q - 2'd1;
                end
                if (stall_cnt_q <= 2'd1) begin
                    state_d = RUN;
                end
            end
            MDU_WAIT: begin
                stall = mdu_pending;
                if (!mdu_pending) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d     = RUN;
                stall_cnt_d = '0;
            end
        endcase
    end

    // MDU latency counter; a new mdu_start while busy restarts the count.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_start) begin
            mdu_cnt_d = MDU_LAT_C;
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
    end

    // Sequencer state and counters; reset aborts any stall in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            mdu_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            mdu_cnt_q   <= mdu_cnt_d;
        end
    end

    // The outputs are combinational, so they are qualified with rst_n to
    // show their reset values for the whole reset pulse regardless of what
    // the pipeline inputs are doing.
    assign pc_write    = !(stall && rst_n);
    assign ifid_write  = !(stall && rst_n);
    assign idex_bubble = stall && rst_n;
    assign ifid_flush  = flush && rst_n;
    assign mdu_busy    = mdu_pending && rst_n;

`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of clocks on which the PC was held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_write && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
`timescale 1ns/1ps
// Testbench for hazard_stall_ctrl. Each cycle's stimulus pushes the expected
// {pc_write, ifid_write, idex_bubble, ifid_flush, mdu_busy} vector into a
// scoreboard queue; the vector is popped and compared on the falling edge.
module tb_hazard_stall_ctrl;

    localparam logic [4:0] RUN0 = 5'b11000;
    localparam logic [4:0] RUN1 = 5'b11001;
    localparam logic [4:0] STL0 = 5'b00100;
    localparam logic [4:0] STL1 = 5'b00101;
    localparam logic [4:0] FLS0 = 5'b11010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_id, rt_id, ex_rd, mem_rd;
    logic        id_uses_rt, id_branch, id_uses_hilo, branch_taken;
    logic        ex_reg_write, ex_mem_read, mem_mem_read, mdu_start;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush, mdu_busy;
    logic [31:0] stall_cycles;
    logic [4:0]  obsVec;

    int compareCount = 0;
    int failCount    = 0;
    int expStalls    = 0;

    logic [4:0] expQ[$];
    string      tagQ[$];

    always #5 clk = ~clk;

    assign obsVec = {pc_write, ifid_write, idex_bubble, ifid_flush, mdu_busy};

    hazard_stall_ctrl #(.MDU_LAT(8), .REG_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .id_uses_rt   (id_uses_rt),
        .id_branch    (id_branch),
        .id_uses_hilo (id_uses_hilo),
        .branch_taken (branch_taken),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .mdu_start    (mdu_start),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .mdu_busy     (mdu_busy),
        .stall_cycles (stall_cycles)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        compareCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drives one cycle of ID/EX/MEM context just after the rising edge,
    // queues the expected output vector, then checks it on the falling edge.
    task automatic applyStimulus(input string tag,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uRt, input logic br,
                                 input logic hilo, input logic tk,
                                 input logic exRw, input logic exMr,
                                 input logic [4:0] exRd,
                                 input logic memMr, input logic [4:0] memRd,
                                 input logic start, input logic [4:0] want);
        logic [4:0] w;
        string      t;
        @(posedge clk);
        #1;
        rs_id        = rs;
        rt_id        = rt;
        id_uses_rt   = uRt;
        id_branch    = br;
        id_uses_hilo = hilo;
        branch_taken = tk;
        ex_reg_write = exRw;
        ex_mem_read  = exMr;
        ex_rd        = exRd;
        mem_mem_read = memMr;
        mem_rd       = memRd;
        mdu_start    = start;
        expQ.push_back(want);
        tagQ.push_back(tag);
        if (want[4] == 1'b0) expStalls++;
        @(negedge clk);
        w = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(t, {27'd0, obsVec}, {27'd0, w});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] statsWant;
        rst_n = 1'b0;
        {rs_id, rt_id, ex_rd, mem_rd} = '0;
        {id_uses_rt, id_branch, id_uses_hilo, branch_taken} = '0;
        {ex_reg_write, ex_mem_read, mem_mem_read, mdu_start} = '0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_out", {27'd0, obsVec}, {27'd0, RUN0});
        checkOutput("reset_stats", stall_cycles, 32'd0);
        rst_n = 1'b1;

        // lw $t0 in EX, add $t1,$t0,$t2 in ID
        applyStimulus("s1_detect", 8, 10, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0, STL0);
        applyStimulus("s1_resume", 8, 10, 1, 0, 0, 0, 0, 0, 0, 1, 8, 0, RUN0);

        // lw $t0 in EX, beq $t0,$t1 taken
        applyStimulus("s2_detect", 8, 9, 1, 1, 0, 1, 1, 1, 8, 0, 0, 0, STL0);
        applyStimulus("s2_hold",   8, 9, 1, 1, 0, 1, 0, 0, 0, 1, 8, 0, STL0);
        applyStimulus("s2_flush",  8, 9, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, FLS0);

        // Second stall cycle must hold even with hazard-free inputs
        applyStimulus("s2b_detect", 8, 9, 1, 1, 0, 1, 1, 1, 8, 0, 0, 0, STL0);
        applyStimulus("s2b_ignore", 8, 9, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, STL0);
        applyStimulus("s2b_flush",  8, 9, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, FLS0);

        // add $t0 in EX, beq $t0,$0 not taken; then a load to $0
        applyStimulus("s3_detect", 8, 0, 1, 1, 0, 0, 1, 0, 8, 0, 0, 0, STL0);
        applyStimulus("s3_resume", 8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 8, 0, RUN0);
        applyStimulus("s3_zero",   0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, RUN0);

        // rt only counts when it is a source; ALU results forward normally
        applyStimulus("rt_unused", 8, 9, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, RUN0);
        applyStimulus("rt_used",   8, 9, 1, 0, 0, 0, 1, 1, 9, 0, 0, 0, STL0);
        applyStimulus("alu_fwd",   8, 9, 1, 0, 0, 0, 1, 0, 8, 0, 0, 0, RUN0);

        // Branch behind a load in MEM, then resolves taken
        applyStimulus("br_mem_load",  8, 9, 1, 1, 0, 1, 0, 0, 0, 1, 9, 0, STL0);
        applyStimulus("br_mem_flush", 8, 9, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, FLS0);

        // Load in EX and load in MEM both match: longest stall wins
        applyStimulus("multi_detect", 8, 9, 1, 1, 0, 0, 1, 1, 8, 1, 9, 0, STL0);
        applyStimulus("multi_hold",   8, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, STL0);
        applyStimulus("multi_done",   8, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, RUN0);

        // mult issuing with mfhi in ID: busy for 9 cycles including start
        applyStimulus("s4_start", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, STL1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus($sformatf("s4_wait%0d", i),
                          0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL1);
        end
        applyStimulus("s4_done", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, RUN0);
        applyStimulus("s4_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN0);

        // MDU restart while busy, then an MDU hazard that also has a
        // load-use match: the MDU wait governs the stall length
        applyStimulus("r_start",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUN1);
        applyStimulus("r_busy1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN1);
        applyStimulus("r_busy2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN1);
        applyStimulus("r_restart", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUN1);
        applyStimulus("prio_det",  8, 0, 0, 0, 1, 0, 1, 1, 8, 0, 0, 0, STL1);
        for (int i = 5; i <= 11; i++) begin
            applyStimulus($sformatf("prio_wait%0d", i),
                          0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL1);
        end
        applyStimulus("prio_done", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, RUN0);

        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN0);
`ifdef STALL_STATS_EN
        statsWant = 32'(expStalls);
`else
        statsWant = 32'd0;
`endif
        checkOutput("stall_total", stall_cycles, statsWant);

        // Reset asserted in the middle of MDU_WAIT
        applyStimulus("m_start", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, STL1);
        applyStimulus("m_wait1", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL1);
        applyStimulus("m_wait2", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, STL1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out", {27'd0, obsVec}, {27'd0, RUN0});
        checkOutput("rst_mid_stats", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_rst_hilo1", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, RUN0);
        applyStimulus("post_rst_hilo2", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, RUN0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, failCount);
        $finish;
    end

endmodule
